rnd_vec_chk: RTL and testbench
==============================

RND_VEC_CHK -- requirements
Module: rnd_vec_chk

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of compared data words.
REQ-002 SHALL have parameter LFSR_LENGTH, default 55, generator register count (lag).
REQ-003 SHALL have parameter LFSR_FEEDBACK, default 24, generator feedback tap (1-based).
REQ-004 SHALL have parameter ERRCNT_WIDTH, default 16, error counter width.
REQ-005 SHALL have clk  input  1  sole clock; all logic on posedge clk.
REQ-006 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have init  input  1  sync seeding strobe; its length sets the generator start state.
REQ-008 SHALL have save, restore  input  1  one-cycle strobes: store or reload generator state.
REQ-009 SHALL have din  input  DATA_WIDTH  read-back data word.
REQ-010 SHALL have din_vld  input  1  din valid, one word per cycle high.
REQ-011 SHALL have clr_err  input  1  clears error counter and first-error capture.
REQ-012 SHALL have expected  output  DATA_WIDTH  current expected word (generator head s[0]).
REQ-013 SHALL have err  output  1  one-cycle mismatch pulse.
REQ-014 SHALL have err_sticky  output  1  set on any mismatch, cleared by clr_err.
REQ-015 SHALL have err_count  output  ERRCNT_WIDTH  saturating mismatch count.
REQ-016 SHALL have word_cnt  output  32  words accepted since last init/restore.
REQ-017 SHALL have first_idx, first_bad, first_exp  output  32/DATA_WIDTH/DATA_WIDTH  word_cnt, din, expected of first mismatch.

Function
REQ-018 SHALL hold generator s[0..L-1] of DATA_WIDTH each, plus store copy t[0..L-1]; expected = s[0].
REQ-019 SHALL step as: sum = s[L-1] + s[F-1] mod 2^DATA_WIDTH; s[i] <= s[i-1] for i>=1; s[0] <= {sum[W-1:1], (OR of all s[i][0]) ? sum[0] : 1}.
REQ-020 SHALL register init as init_d; init & !init_d sets s[0][0] <= 1 (other bits unchanged); init & init_d steps once per cycle.
REQ-021 SHALL apply per-cycle priority: init > restore > save > din_vld; lower-priority events in the same cycle are ignored (dropped, not queued).
REQ-022 SHALL on restore copy t into s and clear word_cnt; on init (either phase) clear word_cnt.
REQ-023 SHALL on save copy s into t; s unchanged.
REQ-024 SHALL on accepted din_vld compare din with expected, step the generator, increment word_cnt (wraps at 2^32).
REQ-025 SHALL register compare result: err pulses high exactly one cycle after the mismatching din_vld cycle.
REQ-026 SHALL on mismatch increment err_count, saturating at all-ones; set err_sticky.
REQ-027 SHALL capture first_idx/first_bad/first_exp only on the first mismatch since reset or clr_err; later mismatches leave them unchanged.
REQ-028 SHALL on clr_err zero err_count, err_sticky and first_* fields; a mismatch registered in the same cycle is applied after clearing (count=1, captured as first).
REQ-029 SHALL not alter err_count, err_sticky or first_* on init, save or restore.

Reset
REQ-030 SHALL on rst asynchronously zero all s, t, init_d, word_cnt, err, err_sticky, err_count and first_*; expected reads 0.
REQ-031 SHALL require init after reset before checking; reset mid-pass discards the pass entirely.

Structure
REQ-032 SHALL place default DATA_WIDTH, LFSR_LENGTH, LFSR_FEEDBACK and ERRCNT_WIDTH constants in the shared test package alongside other DRAM-test constants.
REQ-033 SHALL implement the step logic as a sub-module lfsr_add_step (combinational next-state from s), reusable by write-side generators.

Verification
REQ-034 SHALL verify: rst, init high 1 cycle -> expected=0x0001; feed 0x0001, 23x 0x0000, 0x0001 -> err never high, word_cnt=25, err_count=0.
REQ-035 SHALL verify: after seeding, feed 0x0001 then 0x0004 -> err high cycle after second word, err_count=1, first_idx=1, first_bad=0x0004, first_exp=0x0000.
REQ-036 SHALL verify: save after 10 good words, 5 more words, restore -> expected equals word-10 value, word_cnt=0; replayed 5 words match.
REQ-037 SHALL verify: ERRCNT_WIDTH=4, 20 mismatching words -> err_count=0xF, first_idx=0; clr_err -> count=0, err_sticky=0.
REQ-038 SHALL verify: restore and din_vld in same cycle -> word ignored, no err, generator equals store; rst asserted mid-pass -> all outputs 0 immediately, without clock edge.

Source files
------------

// File: rtl/rnd_vec_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rnd_vec_chk_pkg
// Description : Shared DRAM-test constants and types. Holds the default
//               geometry of the additive lagged-Fibonacci pattern generator,
//               the read-back checker counter widths and the per-cycle
//               action decode shared by the checker.
// Revision    : 1.0 - initial release
// ============================================================================
package rnd_vec_chk_pkg;

    // Pattern generator / checker defaults
    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_LFSR_LENGTH   = 55;
    localparam int DEF_LFSR_FEEDBACK = 24;
    localparam int DEF_ERRCNT_WIDTH  = 16;

    // Other DRAM-test constants
    localparam int WORD_CNT_WIDTH    = 32;

    // One action per cycle; lower-priority requests are dropped, not queued.
    typedef enum logic [2:0] {
        ACT_IDLE      = 3'd0,
        ACT_SEED      = 3'd1,   // rising edge of init: force s[0][0]
        ACT_INIT_STEP = 3'd2,   // init held: advance generator
        ACT_RESTORE   = 3'd3,
        ACT_SAVE      = 3'd4,
        ACT_CHECK     = 3'd5
    } action_e;

    function automatic action_e decode_action(
        input logic init,
        input logic init_d,
        input logic restore,
        input logic save,
        input logic din_vld
    );
        if (init)         return init_d ? ACT_INIT_STEP : ACT_SEED;
        else if (restore) return ACT_RESTORE;
        else if (save)    return ACT_SAVE;
        else if (din_vld) return ACT_CHECK;
        else              return ACT_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rnd_vec_chk_if.sv
`default_nettype none
// ============================================================================
// Module      : rnd_vec_chk_if
// Description : Control/data bundle of the read-back checker.
//               master : drives init/save/restore/din/din_vld/clr_err
//               slave  : the checker; returns expected word, error status,
//                        word counter and first-error capture.
// Revision    : 1.0 - initial release
// ============================================================================
interface rnd_vec_chk_if
    import rnd_vec_chk_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ERRCNT_WIDTH = DEF_ERRCNT_WIDTH
);
    logic                      init;
    logic                      save;
    logic                      restore;
    logic [DATA_WIDTH-1:0]     din;
    logic                      din_vld;
    logic                      clr_err;
    logic [DATA_WIDTH-1:0]     expected;
    logic                      err;
    logic                      err_sticky;
    logic [ERRCNT_WIDTH-1:0]   err_count;
    logic [WORD_CNT_WIDTH-1:0] word_cnt;
    logic [WORD_CNT_WIDTH-1:0] first_idx;
    logic [DATA_WIDTH-1:0]     first_bad;
    logic [DATA_WIDTH-1:0]     first_exp;

    modport master (
        output init, save, restore, din, din_vld, clr_err,
        input  expected, err, err_sticky, err_count, word_cnt,
               first_idx, first_bad, first_exp
    );

    modport slave (
        input  init, save, restore, din, din_vld, clr_err,
        output expected, err, err_sticky, err_count, word_cnt,
               first_idx, first_bad, first_exp
    );
endinterface
`default_nettype wire

// File: rtl/rnd_vec_chk_lfsr_add_step.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_add_step
// Description : Combinational next state of the additive lagged-Fibonacci
//               generator. State is a flat vector, word i at
//               [i*DATA_WIDTH +: DATA_WIDTH]; word 0 is the head.
//               new head = s[L-1] + s[F-1], with its LSB forced to 1 while
//               every stored LSB is 0 (keeps the sequence out of the
//               all-even lock-up). Other words shift up by one.
//   state      in  LFSR_LENGTH*DATA_WIDTH  current generator state
//   next_state out LFSR_LENGTH*DATA_WIDTH  state after one step
//   DATA_WIDTH must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_add_step
    import rnd_vec_chk_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int LFSR_LENGTH   = DEF_LFSR_LENGTH,
    parameter int LFSR_FEEDBACK = DEF_LFSR_FEEDBACK
) (
    input  logic [LFSR_LENGTH*DATA_WIDTH-1:0] state,
    output logic [LFSR_LENGTH*DATA_WIDTH-1:0] next_state
);
    logic [LFSR_LENGTH-1:0] w_lsbs;
    logic [DATA_WIDTH-1:0]  w_sum;
    logic [DATA_WIDTH-1:0]  w_head;

    genvar gi;
    generate
        for (gi = 0; gi < LFSR_LENGTH; gi++) begin : g_lsb
            assign w_lsbs[gi] = state[gi*DATA_WIDTH];
        end
    endgenerate

    assign w_sum  = state[(LFSR_LENGTH-1)*DATA_WIDTH +: DATA_WIDTH]
                  + state[(LFSR_FEEDBACK-1)*DATA_WIDTH +: DATA_WIDTH];
    assign w_head = {w_sum[DATA_WIDTH-1:1], (|w_lsbs) ? w_sum[0] : 1'b1};

    assign next_state = {state[(LFSR_LENGTH-1)*DATA_WIDTH-1:0], w_head};
endmodule
`default_nettype wire

// File: rtl/rnd_vec_chk.sv
`default_nettype none
// ============================================================================
// Module      : rnd_vec_chk
// Description : DRAM read-back checker. Regenerates the write pattern with a
//               lagged-Fibonacci generator, compares each valid read word,
//               and reports errors (pulse, sticky, saturating count and
//               first-error capture). Generator state can be saved/restored
//               to replay a pass.
//   clk   in   sole clock
//   rst   in   asynchronous active-high reset
//   bus   slave modport of rnd_vec_chk_if (controls, din, status outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module rnd_vec_chk
    import rnd_vec_chk_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int LFSR_LENGTH   = DEF_LFSR_LENGTH,
    parameter int LFSR_FEEDBACK = DEF_LFSR_FEEDBACK,
    parameter int ERRCNT_WIDTH  = DEF_ERRCNT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    rnd_vec_chk_if.slave bus
);
    localparam int                    C_STATE_W = LFSR_LENGTH * DATA_WIDTH;
    localparam logic [ERRCNT_WIDTH-1:0] C_CNT_MAX = '1;

    logic [C_STATE_W-1:0]      r_s;
    logic [C_STATE_W-1:0]      r_t;
    logic                      r_init_d;
    logic [WORD_CNT_WIDTH-1:0] r_word_cnt;
    logic                      r_err;
    logic                      r_sticky;
    logic [ERRCNT_WIDTH-1:0]   r_err_count;
    logic [WORD_CNT_WIDTH-1:0] r_first_idx;
    logic [DATA_WIDTH-1:0]     r_first_bad;
    logic [DATA_WIDTH-1:0]     r_first_exp;

    logic [C_STATE_W-1:0]      w_step;
    logic [DATA_WIDTH-1:0]     w_head;
    action_e                   w_action;
    logic                      w_mismatch;

    lfsr_add_step #(
        .DATA_WIDTH    (DATA_WIDTH),
        .LFSR_LENGTH   (LFSR_LENGTH),
        .LFSR_FEEDBACK (LFSR_FEEDBACK)
    ) u_step (
        .state      (r_s),
        .next_state (w_step)
    );

    assign w_head     = r_s[DATA_WIDTH-1:0];
    assign w_action   = decode_action(bus.init, r_init_d, bus.restore,
                                      bus.save, bus.din_vld);
    assign w_mismatch = (w_action == ACT_CHECK) && (bus.din != w_head);

    // Generator, store copy and word counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s        <= '0;
            r_t        <= '0;
            r_init_d   <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_init_d <= bus.init;
            case (w_action)
                ACT_SEED: begin
                    r_s[0]     <= 1'b1;
                    r_word_cnt <= '0;
                end
                ACT_INIT_STEP: begin
                    r_s        <= w_step;
                    r_word_cnt <= '0;
                end
                ACT_RESTORE: begin
                    r_s        <= r_t;
                    r_word_cnt <= '0;
                end
                ACT_SAVE: begin
                    r_t <= r_s;
                end
                ACT_CHECK: begin
                    r_s        <= w_step;
                    r_word_cnt <= r_word_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Error reporting. Clearing happens first so a mismatch landing in the
    // same cycle as clr_err is recorded as the new first error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err       <= 1'b0;
            r_sticky    <= 1'b0;
            r_err_count <= '0;
            r_first_idx <= '0;
            r_first_bad <= '0;
            r_first_exp <= '0;
        end else begin
            r_err <= w_mismatch;
            if (bus.clr_err) begin
                r_sticky    <= 1'b0;
                r_err_count <= '0;
                r_first_idx <= '0;
                r_first_bad <= '0;
                r_first_exp <= '0;
            end
            if (w_mismatch) begin
                r_sticky <= 1'b1;
                if (bus.clr_err) begin
                    r_err_count <= ERRCNT_WIDTH'(1);
                end else if (r_err_count != C_CNT_MAX) begin
                    r_err_count <= r_err_count + 1'b1;
                end
                if (bus.clr_err || !r_sticky) begin
                    r_first_idx <= r_word_cnt;
                    r_first_bad <= bus.din;
                    r_first_exp <= w_head;
                end
            end
        end
    end

    assign bus.expected   = w_head;
    assign bus.err        = r_err;
    assign bus.err_sticky = r_sticky;
    assign bus.err_count  = r_err_count;
    assign bus.word_cnt   = r_word_cnt;
    assign bus.first_idx  = r_first_idx;
    assign bus.first_bad  = r_first_bad;
    assign bus.first_exp  = r_first_exp;
endmodule
`default_nettype wire

// File: tb/tb_rnd_vec_chk.sv
`default_nettype none
// ============================================================================
// Module      : tb_rnd_vec_chk
// Description : Self-checking bench for rnd_vec_chk. Two checkers (16-bit and
//               4-bit error counters) share one stimulus; a queue-based
//               reference model tracks the generated sequence and status.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rnd_vec_chk;
    import rnd_vec_chk_pkg::*;

    localparam int W = 16;
    localparam int L = 55;
    localparam int F = 24;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         init = 1'b0, save = 1'b0, restore = 1'b0;
    logic         din_vld = 1'b0, clr_err = 1'b0;
    logic [W-1:0] din = '0;

    always #5 clk = ~clk;

    rnd_vec_chk_if #(.DATA_WIDTH(W), .ERRCNT_WIDTH(16)) bus  ();
    rnd_vec_chk_if #(.DATA_WIDTH(W), .ERRCNT_WIDTH(4))  bus4 ();

    assign bus.init     = init;     assign bus4.init     = init;
    assign bus.save     = save;     assign bus4.save     = save;
    assign bus.restore  = restore;  assign bus4.restore  = restore;
    assign bus.din      = din;      assign bus4.din      = din;
    assign bus.din_vld  = din_vld;  assign bus4.din_vld  = din_vld;
    assign bus.clr_err  = clr_err;  assign bus4.clr_err  = clr_err;

    rnd_vec_chk #(.DATA_WIDTH(W), .LFSR_LENGTH(L), .LFSR_FEEDBACK(F),
                  .ERRCNT_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    rnd_vec_chk #(.DATA_WIDTH(W), .LFSR_LENGTH(L), .LFSR_FEEDBACK(F),
                  .ERRCNT_WIDTH(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int n_chk = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    logic [W-1:0]  m_s[$];
    logic [W-1:0]  m_t[$];
    logic          m_init_d, m_err, m_sticky;
    logic [15:0]   m_cnt;
    logic [3:0]    m_cnt4;
    logic [31:0]   m_wc, m_fi;
    logic [W-1:0]  m_fb, m_fe;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_clear();
        m_s = {}; m_t = {};
        for (int i = 0; i < L; i++) begin m_s.push_back('0); m_t.push_back('0); end
        m_init_d = 0; m_err = 0; m_sticky = 0; m_cnt = 0; m_cnt4 = 0;
        m_wc = 0; m_fi = 0; m_fb = 0; m_fe = 0;
    endtask

    // x[n+1] = x[n+1-L] + x[n+1-F] with odd-forcing while all stored words are even
    task automatic m_step();
        logic [W-1:0] sum, head;
        logic any_odd;
        sum = m_s[L-1] + m_s[F-1];
        any_odd = 0;
        foreach (m_s[i]) if (m_s[i][0]) any_odd = 1;
        head = sum;
        if (!any_odd) head[0] = 1'b1;
        m_s.push_front(head);
        m_s.delete(L);
    endtask

    task automatic compare_all();
        check("expected",   bus.expected,   m_s[0]);
        check("err",        bus.err,        m_err);
        check("err_sticky", bus.err_sticky, m_sticky);
        check("err_count",  bus.err_count,  m_cnt);
        check("word_cnt",   bus.word_cnt,   m_wc);
        check("first_idx",  bus.first_idx,  m_fi);
        check("first_bad",  bus.first_bad,  m_fb);
        check("first_exp",  bus.first_exp,  m_fe);
        check("err_count4", bus4.err_count, m_cnt4);
    endtask

    // One clock: apply inputs, advance model, compare everything.
    task automatic cycle(input logic a_init, input logic a_save, input logic a_restore,
                         input logic a_vld, input logic [W-1:0] a_din, input logic a_clr);
        logic mis;
        logic [31:0] c_idx;
        logic [W-1:0] c_exp, tmp;
        init = a_init; save = a_save; restore = a_restore;
        din_vld = a_vld; din = a_din; clr_err = a_clr;
        @(posedge clk);
        mis = 0; c_idx = 0; c_exp = 0;
        if (a_init) begin
            if (!m_init_d) begin tmp = m_s[0]; tmp[0] = 1'b1; m_s[0] = tmp; end
            else m_step();
            m_wc = 0;
        end else if (a_restore) begin
            m_s = m_t; m_wc = 0;
        end else if (a_save) begin
            m_t = m_s;
        end else if (a_vld) begin
            mis = (a_din != m_s[0]); c_idx = m_wc; c_exp = m_s[0];
            m_step(); m_wc = m_wc + 1;
        end
        if (a_clr) begin
            m_cnt = 0; m_cnt4 = 0; m_sticky = 0; m_fi = 0; m_fb = 0; m_fe = 0;
        end
        if (mis) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
            if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 1;
            if (!m_sticky) begin m_fi = c_idx; m_fb = a_din; m_fe = c_exp; end
            m_sticky = 1;
        end
        m_err = mis; m_init_d = a_init;
        #1;
        compare_all();
        init = 0; save = 0; restore = 0; din_vld = 0; clr_err = 0;
    endtask

    // Reset asserted between edges: outputs must clear without a clock edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        m_clear();
        check("rst_async_expected",  bus.expected,   0);
        check("rst_async_word_cnt",  bus.word_cnt,   0);
        check("rst_async_err_count", bus.err_count,  0);
        check("rst_async_sticky",    bus.err_sticky, 0);
        check("rst_async_first_idx", bus.first_idx,  0);
        compare_all();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] exp_head;
        logic         exp_err;
    } vec_t;

    vec_t         tbl[25];
    logic [W-1:0] replay[5];
    logic [W-1:0] saved_head;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;

        // ---- seed + known opening of the sequence ----
        do_reset();
        cycle(1, 0, 0, 0, '0, 0);
        check("seed_expected", bus.expected, 16'h0001);
        for (int i = 0; i < 25; i++) begin
            tbl[i].din      = (i == 0 || i == 24) ? 16'h0001 : 16'h0000;
            tbl[i].exp_head = tbl[i].din;
            tbl[i].exp_err  = 1'b0;
        end
        for (int i = 0; i < 25; i++) begin
            check("tbl_head", bus.expected, tbl[i].exp_head);
            cycle(0, 0, 0, 1, tbl[i].din, 0);
            check("tbl_err", bus.err, tbl[i].exp_err);
        end
        check("tbl_word_cnt",  bus.word_cnt,  25);
        check("tbl_err_count", bus.err_count, 0);

        // ---- single mismatch on second word ----
        do_reset();
        cycle(1, 0, 0, 0, '0, 0);
        cycle(0, 0, 0, 1, 16'h0001, 0);
        check("mm_err_first_word", bus.err, 0);
        cycle(0, 0, 0, 1, 16'h0004, 0);
        check("mm_err",       bus.err,       1);
        check("mm_count",     bus.err_count, 1);
        check("mm_first_idx", bus.first_idx, 1);
        check("mm_first_bad", bus.first_bad, 16'h0004);
        check("mm_first_exp", bus.first_exp, 16'h0000);
        cycle(0, 0, 0, 0, '0, 0);
        check("mm_err_pulse_end", bus.err, 0);

        // ---- save / restore replay ----
        do_reset();
        cycle(1, 0, 0, 0, '0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, m_s[0], 0);
        saved_head = m_s[0];
        cycle(0, 1, 0, 0, '0, 0);
        for (int i = 0; i < 5; i++) begin
            replay[i] = m_s[0];
            cycle(0, 0, 0, 1, replay[i], 0);
        end
        cycle(0, 0, 1, 0, '0, 0);
        check("rs_expected", bus.expected, saved_head);
        check("rs_word_cnt", bus.word_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 1, replay[i], 0);
            check("rs_replay_err", bus.err, 0);
        end
        check("rs_replay_count", bus.err_count, 0);

        // ---- counter saturation (4-bit) and clear ----
        do_reset();
        cycle(1, 0, 0, 0, '0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, ~m_s[0], 0);
        check("sat_count4",    bus4.err_count, 4'hF);
        check("sat_count16",   bus.err_count,  20);
        check("sat_first_idx", bus4.first_idx, 0);
        cycle(0, 0, 0, 0, '0, 1);
        check("clr_count4", bus4.err_count,  0);
        check("clr_sticky", bus4.err_sticky, 0);

        // ---- clr_err together with a mismatch ----
        cycle(0, 0, 0, 1, ~m_s[0], 1);
        check("clrmm_count", bus.err_count, 1);
        check("clrmm_idx",   bus.first_idx, 20);

        // ---- restore wins over din_vld; reset mid-pass ----
        do_reset();
        cycle(1, 0, 0, 0, '0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, m_s[0], 0);
        saved_head = m_s[0];
        cycle(0, 1, 0, 0, '0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, m_s[0], 0);
        cycle(0, 0, 1, 1, ~m_s[0], 0);
        check("rv_err",      bus.err,       0);
        check("rv_expected", bus.expected,  saved_head);
        check("rv_word_cnt", bus.word_cnt,  0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, ~m_s[0], 0);
        do_reset();

        // ---- randomized traffic ----
        cycle(1, 0, 0, 0, '0, 0);
        for (int k = 0; k < 400; k++) begin
            logic r_init, r_save, r_rest, r_vld, r_clr;
            logic [W-1:0] r_din;
            r_init = ($urandom_range(0, 99) < 4);
            r_rest = ($urandom_range(0, 99) < 4);
            r_save = ($urandom_range(0, 99) < 5);
            r_vld  = ($urandom_range(0, 99) < 75);
            r_clr  = ($urandom_range(0, 99) < 3);
            r_din  = ($urandom_range(0, 99) < 15) ? W'($urandom) : m_s[0];
            cycle(r_init, r_save, r_rest, r_vld, r_din, r_clr);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
